// File: rtl/ifetch_unit_if.sv
// ----------------------------------------------------------------------------
// ifetch_unit_if
// Instruction-memory read port shared by the fetch unit and memory.
//   imem_req   : read request (fetch unit -> memory)
//   imem_addr  : 32-bit word-aligned read address (fetch unit -> memory)
//   imem_rdata : 32-bit instruction word (memory -> fetch unit)
//   imem_ack   : response strobe; imem_rdata valid in the same cycle
// Modports: master = fetch unit side, slave = memory side.
// ----------------------------------------------------------------------------
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Fetches one instruction at PC, holds it in IR until downstream accepts it,
// then asks the next-PC stage to advance. Misaligned PCs fault permanently
// (until reset).
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   PC         : current program counter
//   stall      : downstream cannot accept a new instruction
//   imem       : instruction-memory port (ifetch_unit_if.master)
//   IR         : instruction register
//   IRvalid    : IR holds an instruction not yet retired
//   PCwr       : PC write enable to the next-PC stage
//   fetch_err  : sticky fetch fault
//
// Parameters:
//   TIMEOUT_CYCLES : fetch cycles without ack before faulting
//   RESET_IR       : IR value after reset (NOP)
//
// Optional feature: define IFETCH_TIMEOUT_EN to enable the ack timeout.
// Without it, FETCH waits for imem_ack indefinitely.
//
// state | meaning
// ------+------------------------------------------------------------
// FETCH | request outstanding at PC, waiting for imem_ack
// ISSUE | IR valid, offered downstream; PCwr = ~stall
// ERR   | fetch fault (misaligned PC or timeout); sticky until reset
// ----------------------------------------------------------------------------
module ifetch_unit #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_IR       = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PC,
  input  logic                 stall,
  ifetch_unit_if.master        imem,
  output logic [31:0]          IR,
  output logic                 IRvalid,
  output logic                 PCwr,
  output logic                 fetch_err
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  logic [1:0] state;
  logic       pc_aligned;
  logic       ack_hit;
  logic       timeout_hit;

  assign pc_aligned = (PC[1:0] == 2'b00);

  // Reset gates the strobes combinationally so nothing leaks out in a reset
  // cycle even though state only changes at the edge.
  assign imem.imem_req  = ~reset & (state == S_FETCH) & pc_aligned;
  assign imem.imem_addr = PC;
  assign PCwr           = ~reset & (state == S_ISSUE) & ~stall;

  // An ack without a request is ignored.
  assign ack_hit = imem.imem_req & imem.imem_ack;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;

  // Counts completed ack-less FETCH cycles; cleared whenever we are not in
  // FETCH so it restarts from zero on every FETCH entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != S_FETCH) begin
      to_cnt <= '0;
    end else if (!ack_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th ack-less cycle; an ack in that same
  // cycle wins because ack_hit is tested first in the FSM.
  assign timeout_hit = (state == S_FETCH) &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      IR        <= RESET_IR;
      IRvalid   <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!pc_aligned) begin
            state     <= S_ERR;
            fetch_err <= 1'b1;
          end else if (ack_hit) begin
            state   <= S_ISSUE;
            IR      <= imem.imem_rdata;
            IRvalid <= 1'b1;
          end else if (timeout_hit) begin
            state     <= S_ERR;
            fetch_err <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            state   <= S_FETCH;
            IRvalid <= 1'b0;
          end
        end
        S_ERR: begin
          IRvalid   <= 1'b0;
          fetch_err <= 1'b1;
        end
        default: begin
          state   <= S_FETCH;
          IRvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
// Directed scenarios followed by a randomized run against a behavioural
// model that tracks "holding an instruction", "faulted" and "cycles waited".
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

  localparam int          TO       = 16;
  localparam logic [31:0] RST_IR   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        stall;
  logic [31:0] IR;
  logic        IRvalid;
  logic        PCwr;
  logic        fetch_err;

  int n_assert = 0;
  int n_fail   = 0;

  ifetch_unit_if imem_bus ();

  ifetch_unit #(
    .TIMEOUT_CYCLES (TO),
    .RESET_IR       (RST_IR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PC        (PC),
    .stall     (stall),
    .imem      (imem_bus),
    .IR        (IR),
    .IRvalid   (IRvalid),
    .PCwr      (PCwr),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  // behavioural model state
  logic [31:0] m_ir;
  logic        m_valid;
  logic        m_err;
  int          m_wait;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic st,
                       input logic ack, input logic [31:0] rd);
    reset               = r;
    PC                  = pc;
    stall               = st;
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rd;
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic model_check();
    logic e_req, e_pcwr;
    e_req  = !reset && !m_err && !m_valid && (PC[1:0] == 2'b00);
    e_pcwr = !reset && !m_err && m_valid && !stall;
    chk("rnd_req",   {31'd0, imem_bus.imem_req}, {31'd0, e_req});
    chk("rnd_addr",  imem_bus.imem_addr, PC);
    chk("rnd_pcwr",  {31'd0, PCwr}, {31'd0, e_pcwr});
    chk("rnd_ir",    IR, m_ir);
    chk("rnd_valid", {31'd0, IRvalid}, {31'd0, m_valid});
    chk("rnd_err",   {31'd0, fetch_err}, {31'd0, m_err});
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    if (reset) begin
      m_ir = RST_IR; m_valid = 1'b0; m_err = 1'b0; m_wait = 0;
    end else if (m_err) begin
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (!stall) begin
        m_valid = 1'b0;
        m_wait  = 0;
      end
    end else if (PC[1:0] != 2'b00) begin
      m_err = 1'b1;
    end else if (imem_bus.imem_ack) begin
      m_ir    = imem_bus.imem_rdata;
      m_valid = 1'b1;
    end else begin
      m_wait++;
`ifdef IFETCH_TIMEOUT_EN
      if (m_wait >= TO) m_err = 1'b1;
`endif
    end
  endtask

  initial begin
    // Reset with a simultaneous ack that must not load IR.
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    settle();
    chk("rst_req",  {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_pcwr", {31'd0, PCwr}, 32'd0);
    tick();
    settle();
    chk("rst_req2", {31'd0, imem_bus.imem_req}, 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("rst_ir",    IR, RST_IR);
    chk("rst_valid", {31'd0, IRvalid}, 32'd0);
    chk("rst_err",   {31'd0, fetch_err}, 32'd0);
    chk("rst_fetch_req", {31'd0, imem_bus.imem_req}, 32'd1);

    // Zero-wait memory: instruction in cycle 1, next request in cycle 2.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2408_0005);
    settle();
    chk("zw_c0_addr", imem_bus.imem_addr, 32'h0);
    chk("zw_c0_pcwr", {31'd0, PCwr}, 32'd0);
    tick();
    settle();
    chk("zw_c1_ir",    IR, 32'h2408_0005);
    chk("zw_c1_valid", {31'd0, IRvalid}, 32'd1);
    chk("zw_c1_pcwr",  {31'd0, PCwr}, 32'd1);
    chk("zw_c1_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    tick();
    imem_bus.imem_ack = 1'b0;
    settle();
    chk("zw_c2_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    chk("zw_c2_valid", {31'd0, IRvalid}, 32'd0);

    // Ack delayed 3 cycles at PC=4.
    drive(1'b0, 32'h4, 1'b0, 1'b0, 32'h1109_0003);
    for (int i = 0; i < 4; i++) begin
      imem_bus.imem_ack = (i == 3);
      settle();
      chk("dly_req",  {31'd0, imem_bus.imem_req}, 32'd1);
      chk("dly_addr", imem_bus.imem_addr, 32'h4);
      chk("dly_pcwr", {31'd0, PCwr}, 32'd0);
      chk("dly_valid", {31'd0, IRvalid}, 32'd0);
      tick();
    end
    imem_bus.imem_ack = 1'b0;
    settle();
    chk("dly_ir",    IR, 32'h1109_0003);
    chk("dly_valid1", {31'd0, IRvalid}, 32'd1);

    // Stall in ISSUE for 5 cycles, then release: PCwr for exactly 1 cycle.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stl_pcwr",  {31'd0, PCwr}, 32'd0);
      chk("stl_ir",    IR, 32'h1109_0003);
      chk("stl_valid", {31'd0, IRvalid}, 32'd1);
      tick();
    end
    stall = 1'b0;
    settle();
    chk("stl_rel_pcwr", {31'd0, PCwr}, 32'd1);
    tick();
    settle();
    chk("stl_after_pcwr",  {31'd0, PCwr}, 32'd0);
    chk("stl_after_valid", {31'd0, IRvalid}, 32'd0);

    // Misaligned PC: no request, sticky fault, IR preserved.
    drive(1'b0, 32'h6, 1'b0, 1'b1, 32'hDEAD_BEEF);
    settle();
    chk("mis_req", {31'd0, imem_bus.imem_req}, 32'd0);
    tick();
    PC = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mis_err",   {31'd0, fetch_err}, 32'd1);
      chk("mis_req2",  {31'd0, imem_bus.imem_req}, 32'd0);
      chk("mis_pcwr",  {31'd0, PCwr}, 32'd0);
      chk("mis_valid", {31'd0, IRvalid}, 32'd0);
      chk("mis_ir",    IR, 32'h1109_0003);
      tick();
    end
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    settle();
    chk("mis_rst_err", {31'd0, fetch_err}, 32'd0);
    chk("mis_rst_ir",  IR, RST_IR);
    chk("mis_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);

`ifdef IFETCH_TIMEOUT_EN
    // No ack: fault after TO fetch cycles.
    for (int i = 0; i < TO; i++) begin
      settle();
      chk("to_wait_err", {31'd0, fetch_err}, 32'd0);
      tick();
    end
    settle();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // Ack on the TO-th cycle wins over the timeout.
    for (int i = 0; i < TO; i++) begin
      imem_bus.imem_ack   = (i == TO - 1);
      imem_bus.imem_rdata = 32'hA5A5_0001;
      tick();
    end
    imem_bus.imem_ack = 1'b0;
    settle();
    chk("to_ack_err", {31'd0, fetch_err}, 32'd0);
    chk("to_ack_ir",  IR, 32'hA5A5_0001);
    stall = 1'b0;
    tick();
`else
    // No timeout: FETCH waits indefinitely.
    for (int i = 0; i < 3 * TO; i++) tick();
    settle();
    chk("nto_err", {31'd0, fetch_err}, 32'd0);
    chk("nto_req", {31'd0, imem_bus.imem_req}, 32'd1);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hA5A5_0001;
    tick();
    imem_bus.imem_ack = 1'b0;
    settle();
    chk("nto_ir", IR, 32'hA5A5_0001);
    tick();
`endif

    // Reset mid-fetch with a simultaneous ack; restart in FETCH afterwards.
    drive(1'b0, 32'h8, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h8, 1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 32'h8, 1'b0, 1'b0, 32'h0);
    settle();
    chk("mid_ir",    IR, RST_IR);
    chk("mid_valid", {31'd0, IRvalid}, 32'd0);
    chk("mid_req",   {31'd0, imem_bus.imem_req}, 32'd1);

    // Randomized run against the model.
    reset = 1'b1;
    model_step();
    tick();
    for (int i = 0; i < 400; i++) begin
      reset               = ($urandom_range(0, 24) == 0);
      PC                  = {$urandom_range(0, 32'h3FFF), 2'b00};
      if ($urandom_range(0, 19) == 0) PC[1:0] = 2'($urandom_range(1, 3));
      stall               = ($urandom_range(0, 2) == 0);
      imem_bus.imem_ack   = ($urandom_range(0, 1) == 1);
      imem_bus.imem_rdata = $urandom;
      settle();
      model_check();
      model_step();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum cycles a fetch waits for imem_ack before faulting (used only when IFETCH_TIMEOUT_EN is defined).
REQ-002 Parameter: RESET_IR, default 32'h0000_0000, value loaded into IR on reset (encodes NOP).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PC  input  32  current program counter from the next-PC stage.
REQ-006 stall  input  1  downstream hold; 1 = decode/execute cannot accept a new instruction.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  read address; equals PC.
REQ-009 imem_rdata  input  32  instruction word returned by memory.
REQ-010 imem_ack  input  1  memory response; imem_rdata valid in the same cycle.
REQ-011 IR  output  32  instruction register.
REQ-012 IRvalid  output  1  IR holds an instruction not yet retired.
REQ-013 PCwr  output  1  PC write enable to the next-PC stage.
REQ-014 fetch_err  output  1  sticky fetch fault flag.

Function
REQ-015 The FSM SHALL have states FETCH, ISSUE and ERR.
REQ-016 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC when PC[1:0]==2'b00.
REQ-017 In FETCH with PC[1:0]!=2'b00, imem_req SHALL be 0 and the FSM SHALL enter ERR at the next edge.
REQ-018 In FETCH, imem_ack==1 SHALL load IR<=imem_rdata, set IRvalid, and move to ISSUE at the same edge.
REQ-019 imem_ack SHALL be ignored in any cycle where imem_req==0.
REQ-020 In ISSUE, PCwr SHALL equal ~stall (combinational); imem_req SHALL be 0.
REQ-021 In ISSUE with stall==0, the FSM SHALL return to FETCH and clear IRvalid at the next edge; with stall==1, IR, IRvalid and state SHALL hold.
REQ-022 PCwr SHALL be 0 in FETCH and ERR.
REQ-023 Zero-wait memory (ack in the request cycle) with stall==0 SHALL yield one instruction every 2 cycles.
REQ-024 In ERR, fetch_err SHALL be 1, imem_req, PCwr and IRvalid SHALL be 0, and the FSM SHALL stay in ERR until reset.
REQ-025 IR SHALL keep its last value in ERR.

Reset
REQ-026 While reset==1, imem_req and PCwr SHALL be 0 regardless of state.
REQ-027 At a rising edge with reset==1: state<=FETCH, IR<=RESET_IR, IRvalid<=0, fetch_err<=0, timeout counter<=0.
REQ-028 Reset SHALL override a simultaneous imem_ack; an ack in a reset cycle SHALL NOT load IR.
REQ-029 Reset asserted mid-fetch or in ERR SHALL abort and restart in FETCH on the first cycle after reset deasserts.

Configuration
REQ-030 Macro IFETCH_TIMEOUT_EN SHALL enable a counter that clears on FETCH entry and increments each FETCH cycle without imem_ack.
REQ-031 With IFETCH_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without ack SHALL move the FSM to ERR at that edge; an ack in the same cycle SHALL take priority.
REQ-032 Without IFETCH_TIMEOUT_EN, no counter SHALL exist and FETCH SHALL wait indefinitely for imem_ack.

Verification
REQ-033 Reset, PC=0x0, ack in every request cycle with rdata=0x2408_0005, stall=0 -> IR=0x2408_0005 and IRvalid=1 in cycle 1; PCwr=1 in cycle 1; next request in cycle 2.
REQ-034 PC=0x4, ack delayed 3 cycles, rdata=0x1109_0003 -> imem_req held 4 cycles with imem_addr=0x4; IR loads on the 4th; PCwr stays 0 throughout FETCH.
REQ-035 In ISSUE, stall=1 for 5 cycles -> PCwr=0, IR and IRvalid unchanged; stall drops -> PCwr=1 for exactly 1 cycle.
REQ-036 PC=0x6 in FETCH -> imem_req=0, fetch_err=1 next cycle and sticky; reset -> fetch_err=0, IR=RESET_IR.
REQ-037 IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> ERR after 16 FETCH cycles; ack on cycle 16 -> IR loaded, no fault.
REQ-038 Reset and ack in the same cycle with rdata=0xFFFF_FFFF -> IR=RESET_IR, IRvalid=0.
